message_block_collector: RTL and testbench
==========================================

Name: message_block_collector

Overview:
- Parametrised successor to the two-word message collector: assembles a fixed-size message block (default 512 bits, SHA-256 block) from multi-word input beats.
- Adds a valid/ready handshake, a block-complete flag with consumer acknowledge, a synchronous abort, and a beat counter.
- Sits between the host/word-loading interface and the hash core; the hash core consumes `message` when `message_valid` is high.

Parameters:
- WORD_SIZE, 32, bits per word.
- WORDS_PER_BEAT, 2, words accepted per handshake beat; TOTAL_WORDS must be an integer multiple of it.
- TOTAL_WORDS, 16, words per message block.
- Derived: BEAT_W = WORD_SIZE*WORDS_PER_BEAT; BEATS = TOTAL_WORDS/WORDS_PER_BEAT; CNT_W = $clog2(BEATS+1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  beat valid; a beat is accepted on a rising clk edge when start && ready.
- data_in  in  BEAT_W  beat data; MS word = earliest word of the beat.
- last  in  1  marks the final beat of a short block (see Optional Feature).
- ack  in  1  consumer has taken the block.
- clear  in  1  synchronous abort of the current block.
- ready  out  1  collector can accept a beat.
- message  out  WORD_SIZE*TOTAL_WORDS  assembled block; word 0 at the MSBs.
- message_valid  out  1  block complete and stable.
- beat_count  out  CNT_W  beats stored in the current block.

Behaviour:
- Reset (reset=0, asynchronous): message=0, message_valid=0, beat_count=0, ready=1.
- ready = !message_valid, combinational from registered state.
- Two states:
  - COLLECT (message_valid=0).
  - FULL (message_valid=1).
- Accepted beat k (k = beat_count before the edge):
  - Written to message[WORD_SIZE*TOTAL_WORDS-1-k*BEAT_W -: BEAT_W].
  - beat_count increments.
  - Write latency: 1 cycle.
- Accepting beat BEATS-1: message_valid=1 and beat_count=BEATS on the same edge; state becomes FULL.
- FULL:
  - message is held constant; start is ignored (ready=0).
  - ack=1 → COLLECT, message_valid=0, beat_count=0.
  - message keeps its contents until overwritten by new beats.
- ack in COLLECT is ignored.
- ack and start in the same FULL cycle: ack takes effect; the beat is NOT accepted and the source must hold it.
- clear=1: beat_count=0, message_valid=0, message=0 on the next edge.
  - Priority: clear > ack > start.
- start low: no state change, regardless of data_in activity.
- beat_count never exceeds BEATS; no wrap-around is possible because ready gates acceptance.
- Reset asserted mid-block discards partial data immediately.

Optional Feature:
- Macro: MESSAGE_BLOCK_COLLECTOR_ZERO_FILL_EN.
- Defined:
  - A beat accepted with last=1 while beat_count < BEATS-1 zero-fills all remaining beat slots after it on the same edge.
  - Sets message_valid=1 and beat_count=BEATS.
  - last on the natural final beat behaves as a normal final beat.
- Undefined: the last input is ignored; a block completes only after BEATS beats.

Test Plan:
- Start held low for 8 beats with data "XXXX Keep your FPGA spinning!" pattern on data_in → beat_count=0, message=0, message_valid=0.
- 8 beats of the padded message (ASCII text, 0x80 pad bit, length word 0x00000180 last) with start=1 → message_valid rises on the 8th accept edge; message equals the 512-bit constant; ready=0.
- While FULL, apply start=1 with data_in=64'h0123456789ABCDEF for 3 cycles, then ack → message unchanged until ack; after ack, ready=1 and beat_count=0.
- 3 beats accepted, then reset=0 for one cycle → message=0, beat_count=0, message_valid=0. Then 8 beats of 64'h0123456789ABCDEF → message = that 64-bit pattern repeated 8 times, message_valid=1.
- 5 beats accepted, then clear and start asserted together → beat_count=0, message=0, beat not stored.
- (ZERO_FILL_EN) 3 beats, last=1 on the 3rd → words 6..15 = 0, message_valid=1, beat_count=8. Without the macro → beat_count=3, message_valid=0.

Source files
------------

// File: rtl/message_block_collector.sv
// message_block_collector: assembles a WORD_SIZE*TOTAL_WORDS message block from WORDS_PER_BEAT-word beats
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   start/ready   beat valid/ready handshake; data_in holds the beat, MS word is the earliest word
//   last          final beat of a short block (used only with MESSAGE_BLOCK_COLLECTOR_ZERO_FILL_EN)
//   ack           consumer has taken the block, reopens collection
//   clear         synchronous abort, empties the block
//   message       assembled block, word 0 at the MSBs
//   message_valid block complete and held stable
//   beat_count    beats stored in the current block
//   Define MESSAGE_BLOCK_COLLECTOR_ZERO_FILL_EN to let `last` zero-fill and close a short block.
module message_block_collector #(
  parameter int WORD_SIZE = 32,
  parameter int WORDS_PER_BEAT = 2,
  parameter int TOTAL_WORDS = 16,
  localparam int BEAT_W = WORD_SIZE * WORDS_PER_BEAT,
  localparam int BEATS = TOTAL_WORDS / WORDS_PER_BEAT,
  localparam int CNT_W = $clog2(BEATS + 1),
  localparam int MSG_W = WORD_SIZE * TOTAL_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BEAT_W-1:0] data_in,
  input  logic              last,
  input  logic              ack,
  input  logic              clear,
  output logic              ready,
  output logic [MSG_W-1:0]  message,
  output logic              message_valid,
  output logic [CNT_W-1:0]  beat_count
);
  typedef enum logic {COLLECT, FULL} state_t;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BEATS);
  state_t state, state_n;
  logic [MSG_W-1:0] msg_n;
  logic [CNT_W-1:0] cnt_n;
`ifndef MESSAGE_BLOCK_COLLECTOR_ZERO_FILL_EN
  logic unused_last;
  assign unused_last = last;
`endif
  assign message_valid = state == FULL;
  assign ready = !message_valid;
  // clear beats ack beats start; in FULL a concurrent start is left for the source to hold
  always_comb begin
    state_n = state;
    msg_n = message;
    cnt_n = beat_count;
    if (clear) begin
      state_n = COLLECT;
      msg_n = '0;
      cnt_n = '0;
    end else if (state == FULL) begin
      if (ack) begin
        state_n = COLLECT;
        cnt_n = '0;
      end
    end else if (start) begin
      msg_n[MSG_W-1-int'(beat_count)*BEAT_W -: BEAT_W] = data_in;
      cnt_n = beat_count + 1'b1;
`ifdef MESSAGE_BLOCK_COLLECTOR_ZERO_FILL_EN
      if (last) begin
        for (int b = 0; b < BEATS; b++)
          if (b > int'(beat_count)) msg_n[MSG_W-1-b*BEAT_W -: BEAT_W] = '0;
        cnt_n = FULL_CNT;
      end
`endif
      state_n = cnt_n == FULL_CNT ? FULL : COLLECT;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= COLLECT;
      message <= '0;
      beat_count <= '0;
    end else begin
      state <= state_n;
      message <= msg_n;
      beat_count <= cnt_n;
    end
  end
endmodule

// File: tb/tb_message_block_collector.sv
// tb_message_block_collector: directed plus random check of message_block_collector against a word-list model
module tb_message_block_collector;
  logic clk = 0, reset = 0, start = 0, last = 0, ack = 0, clear = 0;
  logic [63:0] data_in = '0;
  logic ready, message_valid;
  logic [511:0] message;
  logic [3:0] beat_count;
  int checks = 0, failures = 0;
  logic [31:0] words[16];
  int cnt = 0;
  bit full = 0;
  localparam logic [63:0] PAT = 64'h0123456789ABCDEF;
  logic [383:0] txt = "XXXX Keep your FPGA spinning! SHA-256 test blk..";
  logic [511:0] padded;

  message_block_collector dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in), .last(last),
    .ack(ack), .clear(clear), .ready(ready), .message(message),
    .message_valid(message_valid), .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] model_msg();
    logic [511:0] m;
    for (int i = 0; i < 16; i++) m[511-32*i -: 32] = words[i];
    return m;
  endfunction

  task automatic model_clear_all();
    for (int i = 0; i < 16; i++) words[i] = '0;
    cnt = 0;
    full = 0;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".message"}, message, model_msg());
    chk({tag, ".valid"}, 512'(message_valid), 512'(full));
    chk({tag, ".ready"}, 512'(ready), 512'(!full));
    chk({tag, ".count"}, 512'(beat_count), 512'(cnt));
  endtask

  task automatic step(input string tag, input logic st, input logic [63:0] d,
                      input logic ls, input logic ak, input logic cl);
    start = st; data_in = d; last = ls; ack = ak; clear = cl;
    @(posedge clk);
    if (cl) model_clear_all();
    else if (full) begin
      if (ak) begin full = 0; cnt = 0; end
    end else if (st) begin
      words[2*cnt] = d[63:32];
      words[2*cnt+1] = d[31:0];
      cnt++;
`ifdef MESSAGE_BLOCK_COLLECTOR_ZERO_FILL_EN
      if (ls) begin
        for (int i = 2 * cnt; i < 16; i++) words[i] = '0;
        cnt = 8;
      end
`endif
      if (cnt == 8) full = 1;
    end
    #1;
    chk_all(tag);
    start = 0; last = 0; ack = 0; clear = 0;
  endtask

  initial begin
    model_clear_all();
    padded = {txt, 8'h80, 88'h0, 32'h00000180};
    #3;
    chk_all("reset");
    reset = 1;
    for (int i = 0; i < 8; i++) step("idle", 0, {$urandom, $urandom}, 1, 0, 0);
    for (int i = 0; i < 8; i++) step("padded", 1, padded[511-64*i -: 64], 0, 0, 0);
    chk("padded.const", message, padded);
    for (int i = 0; i < 3; i++) step("full_hold", 1, PAT, 0, 0, 0);
    chk("full_hold.const", message, padded);
    step("ack_start", 1, PAT, 0, 1, 0);
    step("ack_in_collect", 0, PAT, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("partial", 1, {$urandom, $urandom}, 0, 0, 0);
    #2 reset = 0;
    #1;
    model_clear_all();
    chk_all("async_reset");
    #2 reset = 1;
    for (int i = 0; i < 8; i++) step("pat", 1, PAT, 0, 0, 0);
    chk("pat.const", message, {8{PAT}});
    step("ack2", 0, PAT, 0, 1, 0);
    for (int i = 0; i < 5; i++) step("five", 1, {$urandom, $urandom}, 0, 0, 0);
    step("clear_start", 1, PAT, 0, 0, 1);
    step("b1", 1, {$urandom, $urandom}, 0, 0, 0);
    step("b2", 1, {$urandom, $urandom}, 0, 0, 0);
    step("b3_last", 1, {$urandom, $urandom}, 1, 0, 0);
    step("clear_full", 0, PAT, 0, 0, 1);
    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom_range(0, 3) != 0), {$urandom, $urandom},
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 15) == 0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
